// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencing
// controller and its hazard compare sub-module.
package pipe_ctrl_pkg;

    // Controller states. STEP is only reachable when SINGLE_STEP_EN is defined.
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } pc_state_t;

    // Register 0 is hardwired to zero, so writes to it never create a hazard.
    localparam int REG_ZERO = 0;

    // Instruction word loaded into a pipeline register when it is flushed.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // Default widths for the controller parameters.
    localparam int CNT_W_DEF = 16;
    localparam int REG_W_DEF = 3;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect: purely combinational load-use compare between the load in EX
// and the source registers of the instruction in ID. Kept separate so the
// forwarding unit can reuse the same compare.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);

    logic rd_nonzero;
    logic rs1_hit;
    logic rs2_hit;

    // A load into r0 is harmless; only a real source read of the load target stalls.
    always_comb begin
        rd_nonzero = (ex_rd != REG_W'(REG_ZERO));
        rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
        load_use   = ex_is_load && rd_nonzero && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller. Drives PC / IF-ID / ID-EX enables
// and flushes for load-use stalls, taken-branch squash and external halt, and
// keeps saturating stall / flush counters.
// Optional feature macro: SINGLE_STEP_EN (adds step_req port and STEP state).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_branch_taken,
    input  logic             halt_req,
`ifdef SINGLE_STEP_EN
    input  logic             step_req,
`endif
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pc_state_t state;
    pc_state_t state_next;

    logic load_use;

    // Controls an active (RUN or STEP) cycle would produce.
    logic act_pc_en;
    logic act_if_id_en;
    logic act_id_ex_en;
    logic act_if_id_flush;
    logic act_id_ex_flush;
    logic act_branch;
    logic act_stall;
    logic act_normal;

    // Events that close on this edge and bump a counter.
    logic stall_evt;
    logic flush_evt;

    hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    // Priority mux for an active cycle: branch squash beats load-use stall.
    always_comb begin
        act_pc_en       = 1'b1;
        act_if_id_en    = 1'b1;
        act_id_ex_en    = 1'b1;
        act_if_id_flush = 1'b0;
        act_id_ex_flush = 1'b0;
        act_branch      = 1'b0;
        act_stall       = 1'b0;
        act_normal      = 1'b0;
        if (ex_branch_taken) begin
            // ID instruction is squashed, so any load-use on it is irrelevant.
            act_if_id_flush = 1'b1;
            act_id_ex_flush = 1'b1;
            act_branch      = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            act_pc_en       = 1'b0;
            act_if_id_en    = 1'b0;
            act_id_ex_flush = 1'b1;
            act_stall       = 1'b1;
        end else begin
            act_normal      = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; reset forces plain RUN behaviour.
    always_comb begin
        state_next  = state;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        if (rst) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN: begin
                    pc_en       = act_pc_en;
                    if_id_en    = act_if_id_en;
                    id_ex_en    = act_id_ex_en;
                    if_id_flush = act_if_id_flush;
                    id_ex_flush = act_id_ex_flush;
                    stall_evt   = act_stall;
                    flush_evt   = act_branch;
                    // Halt only takes effect after a clean cycle; otherwise it
                    // is re-evaluated next cycle while halt_req stays high.
                    if (halt_req && act_normal) begin
                        state_next = HALT;
                    end
                end
                HALT: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    halted   = 1'b1;
                    if (!halt_req) begin
                        state_next = RUN;
                    end
`ifdef SINGLE_STEP_EN
                    else if (step_req) begin
                        state_next = STEP;
                    end
`endif
                end
`ifdef SINGLE_STEP_EN
                STEP: begin
                    pc_en       = act_pc_en;
                    if_id_en    = act_if_id_en;
                    id_ex_en    = act_id_ex_en;
                    if_id_flush = act_if_id_flush;
                    id_ex_flush = act_id_ex_flush;
                    stall_evt   = act_stall;
                    flush_evt   = act_branch;
                    state_next  = halt_req ? HALT : RUN;
                end
`endif
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_evt && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Saturating flush counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (flush_evt && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
